// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared download-image map, image size and sequencer FSM states
package rom_dl_pkg;
    localparam logic [17:0] CPU_BASE    = 18'h00000;
    localparam logic [17:0] SP_BASE     = 18'h10000;
    localparam logic [17:0] BG_BASE     = 18'h20000;
    localparam logic [17:0] SPCLUT_BASE = 18'h28000;
    localparam logic [17:0] BGCLUT_BASE = 18'h28100;
    localparam logic [17:0] PALET_BASE  = 18'h28200;
    localparam logic [17:0] IMG_SIZE    = 18'h28240;
    typedef enum logic [1:0] {IDLE, LO, HI} state_e;
endpackage

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: splits loader words into byte writes on the ROM download bus
// Ports: DLCL/RST clock and sync reset; IO_DL/IO_WR/IO_AD/IO_DW/IO_WAIT loader side;
// DLAD/DLDT/DLEN byte bus to ROM blocks; DONE/ERR/HOLD image status and core reset.
module rom_dl_sequencer #(
    parameter int AW = 18,
    parameter logic [AW-1:0] IMG_SIZE = AW'(rom_dl_pkg::IMG_SIZE)
) (
    input  logic          DLCL,
    input  logic          RST,
    input  logic          IO_DL,
    input  logic          IO_WR,
    input  logic [24:0]   IO_AD,
    input  logic [15:0]   IO_DW,
    output logic          IO_WAIT,
    output logic [AW-1:0] DLAD,
    output logic [7:0]    DLDT,
    output logic          DLEN,
    output logic          DONE,
    output logic          ERR,
    output logic          HOLD
);
    import rom_dl_pkg::*;

    localparam int CW = AW + 1;

    state_e        state_q;
    logic [AW-1:0] base_q;
    logic [15:0]   word_q;
    logic          bad_q;
    logic          dl_q;
    logic          endp_q;
    logic [CW-1:0] cnt_q;

    logic          rise, fall, acc, drop, odd, issue, byte_bad, byte_ok, evl, img_ok;
    logic [AW-1:0] new_base, byte_adr;
    logic [CW-1:0] cnt_d;
    logic          err_d, done_d, hold_d, endp_d;

    always_comb begin
        rise     = IO_DL & ~dl_q;
        fall     = ~IO_DL & dl_q;
        acc      = IO_WR & IO_DL & (state_q != LO);
        drop     = IO_WR & ~acc;
        odd      = acc & IO_AD[0];
        new_base = {IO_AD[AW-1:1], 1'b0};
        // the byte presented next cycle: high half of the held word, or low half of a new one
        issue    = acc | (state_q == LO);
        byte_adr = (state_q == LO) ? (base_q | AW'(1)) : new_base;
        byte_bad = (state_q == LO) ? bad_q : (|IO_AD[24:AW]);
        byte_ok  = issue & ~byte_bad & (byte_adr < IMG_SIZE);
        // a new download start overrides a pending end evaluation
        evl      = (state_q == IDLE) & endp_q & ~rise;
        img_ok   = (cnt_q == {1'b0, IMG_SIZE}) & ~ERR;
        cnt_d    = rise ? CW'(byte_ok) : (&cnt_q) ? cnt_q : cnt_q + CW'(byte_ok);
        err_d    = (ERR & ~rise) | drop | odd | (issue & ~byte_ok) | (evl & ~img_ok);
        done_d   = ~rise & (evl ? img_ok : DONE);
        hold_d   = rise | (HOLD & ~(evl & img_ok));
        endp_d   = ~rise & (fall | (endp_q & ~evl));
    end

    always_ff @(posedge DLCL) begin
        if (RST) begin
            state_q <= IDLE;
            base_q  <= '0;
            word_q  <= '0;
            bad_q   <= 1'b0;
            dl_q    <= 1'b0;
            endp_q  <= 1'b0;
            cnt_q   <= '0;
            IO_WAIT <= 1'b0;
            DLAD    <= '0;
            DLDT    <= '0;
            DLEN    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            HOLD    <= 1'b1;
        end else begin
            dl_q   <= IO_DL;
            endp_q <= endp_d;
            cnt_q  <= cnt_d;
            ERR    <= err_d;
            DONE   <= done_d;
            HOLD   <= hold_d;
            DLEN   <= byte_ok;
            if (byte_ok) begin
                DLAD <= byte_adr;
                DLDT <= (state_q == LO) ? word_q[15:8] : IO_DW[7:0];
            end
            if (acc) begin
                state_q <= LO;
                word_q  <= IO_DW;
                base_q  <= new_base;
                bad_q   <= |IO_AD[24:AW];
                IO_WAIT <= 1'b1;
            end else begin
                state_q <= (state_q == LO) ? HI : IDLE;
                IO_WAIT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: scoreboard bench for the ROM download sequencer
module tb_rom_dl_sequencer;
    localparam logic [17:0] TB_IMG = 18'h00240;

    logic        DLCL = 1'b0;
    logic        RST = 1'b1;
    logic        IO_DL = 1'b0;
    logic        IO_WR = 1'b0;
    logic [24:0] IO_AD = '0;
    logic [15:0] IO_DW = '0;
    logic        IO_WAIT, DLEN, DONE, ERR, HOLD;
    logic [17:0] DLAD;
    logic [7:0]  DLDT;

    int n_chk = 0;
    int n_fail = 0;
    logic [25:0] exp_q[$];

    always #5 DLCL = ~DLCL;

    rom_dl_sequencer #(.AW(18), .IMG_SIZE(TB_IMG)) dut (
        .DLCL(DLCL), .RST(RST), .IO_DL(IO_DL), .IO_WR(IO_WR), .IO_AD(IO_AD), .IO_DW(IO_DW),
        .IO_WAIT(IO_WAIT), .DLAD(DLAD), .DLDT(DLDT), .DLEN(DLEN),
        .DONE(DONE), .ERR(ERR), .HOLD(HOLD)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge DLCL);
        #1;
    endtask

    task automatic push(input logic [17:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [24:0] ad, input logic [15:0] dw);
        IO_WR = 1'b1;
        IO_AD = ad;
        IO_DW = dw;
        tick();
        IO_WR = 1'b0;
    endtask

    always @(negedge DLCL) begin
        if (DLEN === 1'b1) begin
            if (exp_q.size() == 0) check("dlen_unexpected", 32'(DLEN), 32'd0);
            else check("byte", 32'({DLAD, DLDT}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [15:0] dw;
        repeat (2) tick();
        check("rst_dlen", DLEN, 0);
        check("rst_wait", IO_WAIT, 0);
        check("rst_dlad", DLAD, 0);
        check("rst_dldt", DLDT, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_hold", HOLD, 1);
        RST = 1'b0;
        IO_DL = 1'b1;
        tick();
        push(18'h10, 8'hEF);
        push(18'h11, 8'hBE);
        send(25'h10, 16'hBEEF);
        check("w1_lo_en", DLEN, 1);
        check("w1_lo_ad", DLAD, 18'h10);
        check("w1_lo_dt", DLDT, 8'hEF);
        check("w1_lo_wait", IO_WAIT, 1);
        tick();
        check("w1_hi_en", DLEN, 1);
        check("w1_hi_ad", DLAD, 18'h11);
        check("w1_hi_dt", DLDT, 8'hBE);
        check("w1_hi_wait", IO_WAIT, 0);
        tick();
        check("w1_idle_en", DLEN, 0);
        IO_DL = 1'b0;
        tick();
        tick();
        check("short_err", ERR, 1);
        check("short_done", DONE, 0);
        check("short_hold", HOLD, 1);
        IO_DL = 1'b1;
        tick();
        check("rise_clr_err", ERR, 0);
        check("rise_hold", HOLD, 1);
        for (int i = 0; i < int'(TB_IMG) / 2; i++) begin
            dw = 16'($urandom);
            push(18'(2 * i), dw[7:0]);
            push(18'(2 * i + 1), dw[15:8]);
            send(25'(2 * i), dw);
            tick();
        end
        IO_DL = 1'b0;
        tick();
        check("full_done_early", DONE, 0);
        tick();
        check("full_done", DONE, 1);
        check("full_hold", HOLD, 0);
        check("full_err", ERR, 0);
        check("full_drained", exp_q.size(), 0);
        IO_DL = 1'b1;
        tick();
        check("rise_done_clr", DONE, 0);
        check("rise_hold_set", HOLD, 1);
        send(25'(TB_IMG), 16'h1111);
        check("oor_lo_en", DLEN, 0);
        tick();
        check("oor_hi_en", DLEN, 0);
        check("oor_err", ERR, 1);
        send(25'h1000010, 16'h2222);
        check("hibits_lo_en", DLEN, 0);
        tick();
        check("hibits_hi_en", DLEN, 0);
        IO_DL = 1'b0;
        tick();
        tick();
        check("oor_done", DONE, 0);
        check("oor_hold", HOLD, 1);
        check("oor_err_end", ERR, 1);
        IO_DL = 1'b1;
        tick();
        check("pv_start_err", ERR, 0);
        push(18'h30, 8'h34);
        push(18'h31, 8'h12);
        send(25'h30, 16'h1234);
        check("pv_wait", IO_WAIT, 1);
        send(25'h40, 16'hAAAA);
        check("pv_hi_en", DLEN, 1);
        check("pv_hi_ad", DLAD, 18'h31);
        check("pv_err", ERR, 1);
        tick();
        check("pv_dropped", DLEN, 0);
        push(18'h50, 8'h78);
        push(18'h51, 8'h56);
        send(25'h51, 16'h5678);
        check("odd_ad", DLAD, 18'h50);
        tick();
        tick();
        push(18'h60, 8'hBC);
        send(25'h60, 16'h9ABC);
        RST = 1'b1;
        IO_DL = 1'b0;
        tick();
        check("mid_rst_dlen", DLEN, 0);
        check("mid_rst_wait", IO_WAIT, 0);
        check("mid_rst_dlad", DLAD, 0);
        check("mid_rst_dldt", DLDT, 0);
        check("mid_rst_err", ERR, 0);
        check("mid_rst_done", DONE, 0);
        check("mid_rst_hold", HOLD, 1);
        RST = 1'b0;
        tick();
        send(25'h70, 16'h7777);
        check("nodl_en", DLEN, 0);
        check("nodl_err", ERR, 1);
        tick();
        tick();
        check("drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
